// File: rtl/aes_pkg.sv
//------------------------------------------------------------------------------
// aes_pkg : shared AES types, byte-index helper and default state address
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package aes_pkg;

    typedef logic [127:0] aes_state_t;
    typedef logic [7:0]   aes_byte_t;

    localparam logic [15:0] c_DEFAULT_STATE_ADDR = 16'd32;

    // Column-major byte index of element s[r][c]; byte i lives at [127-8i -: 8]
    function automatic int idx(input int r, input int c);
        return r + 4 * c;
    endfunction

endpackage : aes_pkg

`default_nettype wire

// File: rtl/srows_perm.sv
//------------------------------------------------------------------------------
// srows_perm : combinational ShiftRows byte permutation (InvShiftRows when
//              SROWS_INV_EN is defined)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module srows_perm
    import aes_pkg::*;
(
    input  aes_state_t i_state,
    output aes_state_t o_state
);

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
`ifdef SROWS_INV_EN
            localparam int c_SRC_COL = (c - r + 4) % 4;
`else
            localparam int c_SRC_COL = (c + r) % 4;
`endif
            localparam int c_DST = idx(r, c);
            localparam int c_SRC = idx(r, c_SRC_COL);
            assign o_state[127-8*c_DST -: 8] = i_state[127-8*c_SRC -: 8];
        end
    end

endmodule : srows_perm

`default_nettype wire

// File: rtl/aes_srows.sv
//------------------------------------------------------------------------------
// aes_srows : read AES state from SRAM, apply ShiftRows, write it back.
//             Define SROWS_INV_EN to build InvShiftRows instead.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module aes_srows
    import aes_pkg::*;
#(
    parameter logic [15:0] STATE_ADDR = c_DEFAULT_STATE_ADDR
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic [127:0] sramReadValue,
    input  logic         srows_enable,
    output logic         srows_finished,
    output logic [127:0] sramWriteValue,
    output logic         sramRead,
    output logic         sramWrite,
    output logic         sramDump,
    output logic         sramInit,
    output logic [15:0]  sramAddr,
    output logic [2:0]   sramDumpNum,
    output logic [2:0]   sramInitNum
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_LATCH = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    aes_state_t r_data;
    aes_state_t w_perm;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
            r_data  <= '0;
        end else begin
            r_state <= w_next_state;
            // SRAM data arrives one cycle after the read strobe
            if (r_state == S_LATCH) begin
                r_data <= sramReadValue;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (srows_enable) w_next_state = S_READ;
            S_READ:  w_next_state = S_LATCH;
            S_LATCH: w_next_state = S_WRITE;
            S_WRITE: w_next_state = S_DONE;
            S_DONE:  if (!srows_enable) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        sramRead       = 1'b0;
        sramWrite      = 1'b0;
        sramAddr       = 16'd0;
        srows_finished = 1'b0;
        case (r_state)
            S_READ: begin
                sramRead = 1'b1;
                sramAddr = STATE_ADDR;
            end
            S_LATCH: sramAddr = STATE_ADDR;
            S_WRITE: begin
                sramWrite = 1'b1;
                sramAddr  = STATE_ADDR;
            end
            S_DONE:  srows_finished = 1'b1;
            default: ;
        endcase
    end

    srows_perm u_perm (
        .i_state (r_data),
        .o_state (w_perm)
    );

    assign sramWriteValue = w_perm;
    assign sramDump       = 1'b0;
    assign sramInit       = 1'b0;
    assign sramDumpNum    = 3'd0;
    assign sramInitNum    = 3'd0;

endmodule : aes_srows

`default_nettype wire

// File: tb/tb_aes_srows.sv
//------------------------------------------------------------------------------
// tb_aes_srows : self-checking bench for aes_srows with SRAM model and
//                write-data scoreboard
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_aes_srows;

    localparam logic [15:0] c_ADDR = 16'd32;
    localparam logic [127:0] c_VEC_IN  = 128'h112233445566778899AABBCCDDEEFF00;
`ifdef SROWS_INV_EN
    localparam logic [127:0] c_VEC_OUT = 128'h11EEBB885522FFCC99663300DDAA7744;
`else
    localparam logic [127:0] c_VEC_OUT = 128'h1166BB0055AAFF4499EE3388DD2277CC;
`endif

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic [127:0] sramReadValue;
    logic         srows_enable = 1'b0;
    logic         srows_finished;
    logic [127:0] sramWriteValue;
    logic         sramRead, sramWrite, sramDump, sramInit;
    logic [15:0]  sramAddr;
    logic [2:0]   sramDumpNum, sramInitNum;

    int n_cmp = 0;
    int n_err = 0;
    int n_reads = 0;
    int n_writes = 0;
    int n_overlap = 0;
    logic [127:0] mem_word = '0;
    logic [127:0] rd_data = '0;
    logic [127:0] sb_q[$];

    always #5 clk = ~clk;

    aes_srows #(.STATE_ADDR(c_ADDR)) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .sramReadValue  (sramReadValue),
        .srows_enable   (srows_enable),
        .srows_finished (srows_finished),
        .sramWriteValue (sramWriteValue),
        .sramRead       (sramRead),
        .sramWrite      (sramWrite),
        .sramDump       (sramDump),
        .sramInit       (sramInit),
        .sramAddr       (sramAddr),
        .sramDumpNum    (sramDumpNum),
        .sramInitNum    (sramInitNum)
    );

    // 1-cycle-latency SRAM: valid data only in the cycle after a read at c_ADDR
    always @(posedge clk) begin
        rd_data <= (sramRead && sramAddr == c_ADDR) ? mem_word : 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    end
    assign sramReadValue = rd_data;

    task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            int r, c, sc;
            r = i % 4;
            c = i / 4;
`ifdef SROWS_INV_EN
            sc = (c + 4 - r) % 4;
`else
            sc = (c + r) % 4;
`endif
            o[127-8*i -: 8] = s[127-8*(r+4*sc) -: 8];
        end
        return o;
    endfunction

    always @(negedge clk) begin
        if (sramRead && sramWrite) n_overlap++;
        if (sramRead) begin
            n_reads++;
            check_value("read_addr", 128'(sramAddr), 128'(c_ADDR));
        end
        if (sramWrite) begin
            n_writes++;
            check_value("write_expected", 128'(sb_q.size() != 0), 128'd1);
            check_value("write_addr", 128'(sramAddr), 128'(c_ADDR));
            if (sb_q.size() != 0) check_value("write_data", sramWriteValue, sb_q.pop_front());
        end
    end

    // Called at a negedge; returns cycles from the enable-sampling edge to finished
    task automatic run_op(input logic [127:0] data, output int lat);
        mem_word = data;
        sb_q.push_back(model(data));
        srows_enable = 1'b1;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!srows_finished && lat < 20);
    endtask

    initial begin
        int lat, r0, w0, fin_cnt;

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_value("rst_finished", 128'(srows_finished), 128'd0);
        check_value("rst_wdata", sramWriteValue, 128'd0);
        check_value("rst_read", 128'(sramRead), 128'd0);
        check_value("rst_write", 128'(sramWrite), 128'd0);
        check_value("rst_addr", 128'(sramAddr), 128'd0);
        check_value("rst_tied", 128'({sramDump, sramInit, sramDumpNum, sramInitNum}), 128'd0);
        n_rst = 1'b1;
        @(negedge clk);

        // Known vector
        run_op(c_VEC_IN, lat);
        check_value("vec_latency", 128'(lat), 128'd4);
        check_value("vec_wdata_const", sramWriteValue, c_VEC_OUT);
        srows_enable = 1'b0;
        @(negedge clk);
        check_value("vec_idle_fin", 128'(srows_finished), 128'd0);
        check_value("vec_idle_addr", 128'(sramAddr), 128'd0);

        // Enable held high for 10 cycles
        r0 = n_reads;
        w0 = n_writes;
        mem_word = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
        sb_q.push_back(model(mem_word));
        srows_enable = 1'b1;
        repeat (10) @(negedge clk);
        check_value("hold_reads", 128'(n_reads - r0), 128'd1);
        check_value("hold_writes", 128'(n_writes - w0), 128'd1);
        check_value("hold_finished", 128'(srows_finished), 128'd1);
        srows_enable = 1'b0;
        @(negedge clk);
        check_value("hold_release", 128'(srows_finished), 128'd0);

        // Reset during LATCH
        r0 = n_reads;
        w0 = n_writes;
        mem_word = 128'hCAFEF00D_0123_4567_89AB_CDEF_FEDCBA98;
        srows_enable = 1'b1;
        @(negedge clk);
        srows_enable = 1'b0;
        @(negedge clk);
        check_value("latch_addr", 128'(sramAddr), 128'(c_ADDR));
        n_rst = 1'b0;
        @(negedge clk);
        check_value("rstl_write", 128'(sramWrite), 128'd0);
        check_value("rstl_addr", 128'(sramAddr), 128'd0);
        check_value("rstl_wdata", sramWriteValue, 128'd0);
        n_rst = 1'b1;
        repeat (6) @(negedge clk);
        check_value("rstl_writes", 128'(n_writes - w0), 128'd0);
        check_value("rstl_reads", 128'(n_reads - r0), 128'd1);
        check_value("rstl_finished", 128'(srows_finished), 128'd0);

        // One-cycle enable pulse
        w0 = n_writes;
        mem_word = 128'h00112233445566778899AABBCCDDEEFF;
        sb_q.push_back(model(mem_word));
        srows_enable = 1'b1;
        @(negedge clk);
        srows_enable = 1'b0;
        fin_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (srows_finished) fin_cnt++;
        end
        check_value("pulse_fin_cycles", 128'(fin_cnt), 128'd1);
        check_value("pulse_writes", 128'(n_writes - w0), 128'd1);
        check_value("pulse_idle_addr", 128'(sramAddr), 128'd0);

        // Random states
        repeat (4) begin
            run_op({$urandom, $urandom, $urandom, $urandom}, lat);
            check_value("rand_latency", 128'(lat), 128'd4);
            srows_enable = 1'b0;
            @(negedge clk);
        end

        repeat (2) @(negedge clk);
        check_value("sb_drained", 128'(sb_q.size()), 128'd0);
        check_value("rw_overlap", 128'(n_overlap), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_aes_srows

`default_nettype wire
